// File: rtl/stopwatch_core.sv
`timescale 1ns/1ps
// MM:SS.t BCD stopwatch: run/pause/lap/clear FSM driven by command pulses.
// Counts prescaler ticks and muxes the live or lap-frozen value to the digits.
module stopwatch_core #(
  parameter int MIN_TENS_MAX = 5,
  parameter bit HOLD_AT_MAX  = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tenth_tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_lo,
  output logic [3:0] disp_sec_hi,
  output logic [3:0] disp_min_lo,
  output logic [3:0] disp_min_hi,
  output logic       running,
  output logic       lap_active,
  output logic       wrap_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  localparam logic [3:0] MH_MAX = 4'(MIN_TENS_MAX);

  state_t     state, state_n;
  logic [3:0] c_t, c_sl, c_sh, c_ml, c_mh;
  logic [3:0] c_t_n, c_sl_n, c_sh_n, c_ml_n, c_mh_n;
  logic [3:0] l_t, l_sl, l_sh, l_ml, l_mh;
  logic [3:0] l_t_n, l_sl_n, l_sh_n, l_ml_n, l_mh_n;
  logic       wrap, wrap_n;
  logic       counting, adv, at_max;

  assign counting = (state == RUN) || (state == LAP);
  // commands win over a coincident tick
  assign adv = tenth_tick && counting && !clear && !start_stop;
  assign at_max = (c_t == 4'd9) && (c_sl == 4'd9) && (c_sh == 4'd5)
               && (c_ml == 4'd9) && (c_mh == MH_MAX);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      c_t   <= '0;
      c_sl  <= '0;
      c_sh  <= '0;
      c_ml  <= '0;
      c_mh  <= '0;
      l_t   <= '0;
      l_sl  <= '0;
      l_sh  <= '0;
      l_ml  <= '0;
      l_mh  <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      c_t   <= c_t_n;
      c_sl  <= c_sl_n;
      c_sh  <= c_sh_n;
      c_ml  <= c_ml_n;
      c_mh  <= c_mh_n;
      l_t   <= l_t_n;
      l_sl  <= l_sl_n;
      l_sh  <= l_sh_n;
      l_ml  <= l_ml_n;
      l_mh  <= l_mh_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    c_t_n   = c_t;
    c_sl_n  = c_sl;
    c_sh_n  = c_sh;
    c_ml_n  = c_ml;
    c_mh_n  = c_mh;
    l_t_n   = l_t;
    l_sl_n  = l_sl;
    l_sh_n  = l_sh;
    l_ml_n  = l_ml;
    l_mh_n  = l_mh;
    wrap_n  = 1'b0;

    priority case (1'b1)
      clear: begin
        state_n = IDLE;
        c_t_n   = '0;
        c_sl_n  = '0;
        c_sh_n  = '0;
        c_ml_n  = '0;
        c_mh_n  = '0;
        l_t_n   = '0;
        l_sl_n  = '0;
        l_sh_n  = '0;
        l_ml_n  = '0;
        l_mh_n  = '0;
      end
      start_stop: state_n = counting ? PAUSE : RUN;
      lap: begin
        if (state == RUN) begin
          state_n = LAP;
          l_t_n   = c_t;
          l_sl_n  = c_sl;
          l_sh_n  = c_sh;
          l_ml_n  = c_ml;
          l_mh_n  = c_mh;
        end else if (state == LAP) begin
          state_n = RUN;
        end
      end
      default: ;
    endcase

    if (adv) begin
      if (at_max) begin
        wrap_n = 1'b1;
        if (HOLD_AT_MAX) begin
          state_n = PAUSE;
        end else begin
          c_t_n  = '0;
          c_sl_n = '0;
          c_sh_n = '0;
          c_ml_n = '0;
          c_mh_n = '0;
        end
      end else if (c_t != 4'd9) begin
        c_t_n = c_t + 4'd1;
      end else begin
        c_t_n = '0;
        if (c_sl != 4'd9) begin
          c_sl_n = c_sl + 4'd1;
        end else begin
          c_sl_n = '0;
          if (c_sh != 4'd5) begin
            c_sh_n = c_sh + 4'd1;
          end else begin
            c_sh_n = '0;
            if (c_ml != 4'd9) begin
              c_ml_n = c_ml + 4'd1;
            end else begin
              c_ml_n = '0;
              c_mh_n = c_mh + 4'd1;
            end
          end
        end
      end
    end
  end

  assign running     = counting;
  assign lap_active  = (state == LAP);
  assign wrap_pulse  = wrap;
  assign disp_tenths = lap_active ? l_t  : c_t;
  assign disp_sec_lo = lap_active ? l_sl : c_sl;
  assign disp_sec_hi = lap_active ? l_sh : c_sh;
  assign disp_min_lo = lap_active ? l_ml : c_ml;
  assign disp_min_hi = lap_active ? l_mh : c_mh;

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
// Bench for stopwatch_core: directed scenarios plus random command traffic
// against a tenths-count reference model, for both wrap and hold variants.
module tb_stopwatch_core;

  localparam int MTM  = 5;
  localparam int FULL = (MTM * 10 + 9) * 600 + 599;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tenth_tick = 1'b0;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;

  logic [3:0] a_t, a_sl, a_sh, a_ml, a_mh;
  logic [3:0] b_t, b_sl, b_sh, b_ml, b_mh;
  logic       a_run, a_lap, a_wrap;
  logic       b_run, b_lap, b_wrap;
  logic [19:0] da, db;

  int errors = 0;
  int checks = 0;

  mstate_t ms[2];
  int      mcnt[2];
  int      mlapv[2];
  bit      mwrap[2];

  always #5 clk = ~clk;

  stopwatch_core #(.MIN_TENS_MAX(MTM), .HOLD_AT_MAX(1'b0)) dut_wrap (
    .CLOCK_50(clk), .reset(reset), .tenth_tick(tenth_tick),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_tenths(a_t), .disp_sec_lo(a_sl), .disp_sec_hi(a_sh),
    .disp_min_lo(a_ml), .disp_min_hi(a_mh),
    .running(a_run), .lap_active(a_lap), .wrap_pulse(a_wrap)
  );

  stopwatch_core #(.MIN_TENS_MAX(MTM), .HOLD_AT_MAX(1'b1)) dut_hold (
    .CLOCK_50(clk), .reset(reset), .tenth_tick(tenth_tick),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_tenths(b_t), .disp_sec_lo(b_sl), .disp_sec_hi(b_sh),
    .disp_min_lo(b_ml), .disp_min_hi(b_mh),
    .running(b_run), .lap_active(b_lap), .wrap_pulse(b_wrap)
  );

  assign da = {a_mh, a_ml, a_sh, a_sl, a_t};
  assign db = {b_mh, b_ml, b_sh, b_sl, b_t};

  function automatic logic [19:0] to_bcd(input int v);
    int mm, ss;
    mm = v / 600;
    ss = (v % 600) / 10;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(v % 10)};
  endfunction

  function automatic logic [19:0] exp_disp(input int k);
    return to_bcd(ms[k] == M_LAP ? mlapv[k] : mcnt[k]);
  endfunction

  function automatic bit exp_run(input int k);
    return ms[k] == M_RUN || ms[k] == M_LAP;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = M_IDLE;
      mcnt[k] = 0;
      mlapv[k] = 0;
      mwrap[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit tk, input bit ss, input bit lp, input bit cl);
    for (int k = 0; k < 2; k++) begin
      bit live;
      live = exp_run(k);
      mwrap[k] = 1'b0;
      if (cl) begin
        ms[k] = M_IDLE;
        mcnt[k] = 0;
        mlapv[k] = 0;
      end else if (ss) begin
        ms[k] = live ? M_PAUSE : M_RUN;
      end else begin
        if (lp && ms[k] == M_RUN) begin
          mlapv[k] = mcnt[k];
          ms[k] = M_LAP;
        end else if (lp && ms[k] == M_LAP) begin
          ms[k] = M_RUN;
        end
        if (tk && live) begin
          if (mcnt[k] == FULL) begin
            mwrap[k] = 1'b1;
            if (k == 1) ms[k] = M_PAUSE;
            else mcnt[k] = 0;
          end else begin
            mcnt[k] = mcnt[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit tk, input bit ss, input bit lp, input bit cl);
    tenth_tick = tk;
    start_stop = ss;
    lap = lp;
    clear = cl;
    @(posedge clk);
    model_step(tk, ss, lp, cl);
    #1;
    tenth_tick = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #3;
    checks++;
    if ({da, a_run, a_lap, a_wrap} !== 23'd0) begin
      errors++;
      $display("FAIL reset_wrap: got %h want 0", {da, a_run, a_lap, a_wrap});
    end
    checks++;
    if ({db, b_run, b_lap, b_wrap} !== 23'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", {db, b_run, b_lap, b_wrap});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ticks(3);
    checks++;
    if (da !== 20'h00000 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_ticks: got %h run %b want 00000 run 0", da, a_run);
    end
  endtask

  task automatic test_basic_count();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    checks++;
    if (da !== 20'h00010 || a_run !== 1'b1 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: got %h run %b wrap %b want 00010 1 0",
               da, a_run, a_wrap);
    end
  endtask

  task automatic test_minute_carry();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(599);
    checks++;
    if (da !== 20'h00599) begin
      errors++;
      $display("FAIL preload_599: got %h want 00599", da);
    end
    ticks(1);
    checks++;
    if (da !== 20'h01000) begin
      errors++;
      $display("FAIL minute_carry: got %h want 01000", da);
    end
  endtask

  task automatic test_lap();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(34);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (da !== 20'h00034 || a_lap !== 1'b1 || a_run !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: got %h lap %b run %b want 00034 1 1", da, a_lap, a_run);
    end
    ticks(5);
    checks++;
    if (da !== 20'h00034) begin
      errors++;
      $display("FAIL lap_frozen: got %h want 00034", da);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (da !== 20'h00039 || a_lap !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: got %h lap %b want 00039 0", da, a_lap);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (da !== 20'h00042 || a_lap !== 1'b0 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL lap_tick_then_pause: got %h lap %b run %b want 00042 0 0",
               da, a_lap, a_run);
    end
  endtask

  task automatic test_pause_coincident();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (da !== 20'h00007 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL pause_with_tick: got %h run %b want 00007 0", da, a_run);
    end
    ticks(5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (da !== 20'h00007 || a_lap !== 1'b0) begin
      errors++;
      $display("FAIL paused_hold: got %h lap %b want 00007 0", da, a_lap);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (da !== 20'h00007 || a_run !== 1'b1) begin
      errors++;
      $display("FAIL resume_with_tick: got %h run %b want 00007 1", da, a_run);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(23);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (da !== 20'h00000 || a_run !== 1'b0 || a_lap !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: got %h run %b lap %b want 00000 0 0",
               da, a_run, a_lap);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_run !== 1'b1) begin
      errors++;
      $display("FAIL clear_to_idle: got run %b want 1", a_run);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(12);
    reset = 1'b1;
    #2;
    checks++;
    if ({da, a_run, a_lap, a_wrap} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {da, a_run, a_lap, a_wrap});
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({da, a_run, a_wrap} !== 22'd0) begin
      errors++;
      $display("FAIL reset_release: got %h want 0", {da, a_run, a_wrap});
    end
  endtask

  task automatic test_full_scale();
    int wa, wb;
    wa = 0;
    wb = 0;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FULL + 1; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (a_wrap === 1'b1) wa++;
      if (b_wrap === 1'b1) wb++;
    end
    checks++;
    if (da !== 20'h00000 || wa != 1 || a_run !== 1'b1) begin
      errors++;
      $display("FAIL wrap_variant: got %h wraps %0d run %b want 00000 1 1", da, wa, a_run);
    end
    checks++;
    if (db !== 20'h59599 || wb != 1 || b_run !== 1'b0) begin
      errors++;
      $display("FAIL hold_variant: got %h wraps %0d run %b want 59599 1 0", db, wb, b_run);
    end
    ticks(4);
    if (a_wrap === 1'b1) wa++;
    if (b_wrap === 1'b1) wb++;
    checks++;
    if (da !== 20'h00004 || db !== 20'h59599 || wa != 1 || wb != 1) begin
      errors++;
      $display("FAIL after_full_scale: got %h %h wraps %0d %0d want 00004 59599 1 1",
               da, db, wa, wb);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit tk, ss, lp, cl;
      tk = ($urandom_range(1, 0) == 1);
      ss = ($urandom_range(15, 0) == 0);
      lp = ($urandom_range(9, 0) == 0);
      cl = ($urandom_range(199, 0) == 0);
      cycle(tk, ss, lp, cl);
      for (int k = 0; k < 2; k++) begin
        logic [19:0] d;
        logic r, l, w;
        d = (k == 0) ? da : db;
        r = (k == 0) ? a_run : b_run;
        l = (k == 0) ? a_lap : b_lap;
        w = (k == 0) ? a_wrap : b_wrap;
        checks++;
        if ({d, r, l, w} !== {exp_disp(k), exp_run(k), ms[k] == M_LAP, mwrap[k]}) begin
          errors++;
          bad++;
          if (bad <= 10)
            $display("FAIL random[%0d] dut%0d: got %h %b%b%b want %h %b%b%b", i, k,
                     d, r, l, w, exp_disp(k), exp_run(k), ms[k] == M_LAP, mwrap[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_count();
    test_minute_carry();
    test_lap();
    test_pause_coincident();
    test_clear_priority();
    test_async_reset();
    test_full_scale();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
